// File: rtl/nonrestoring_div16_pkg.sv
// Shared types and constants for the 32/16 unsigned non-restoring divider.
// Optional feature macro: DIV0_CHECK_EN (divide-by-zero short cut).
package nonrestoring_div16_pkg;

    localparam int DW        = 16;
    localparam int CNT_W     = $clog2(DW);
    localparam int ITER_LAST = DW - 1;

    typedef enum logic [3:0] {
        LD_A0,
        LD_A,
        LD_Q0,
        LD_Q,
        LD_M0,
        LD_M,
        SHIFT,
        ADDSUB,
        CORRECT,
        OUT_R,
        OUT_Q,
        DONE
    } state_t;

endpackage

// File: rtl/nonrestoring_div16_addsub17.sv
// Combinational 17-bit {S,A} +/- {0,M}; subtract is add of ~{0,M} with cin=1.
// Carry out of bit 16 is discarded.
module div_addsub17
    import nonrestoring_div16_pkg::*;
(
    input  logic [DW:0]   sa,
    input  logic [DW-1:0] m,
    input  logic          sub,
    output logic [DW:0]   sum
);

    logic [DW:0] operand;

    // Invert the zero-extended divisor for subtraction, carry-in supplies the +1.
    always_comb begin
        operand = sub ? ~{1'b0, m} : {1'b0, m};
        sum     = sa + operand + {{DW{1'b0}}, sub};
    end

endmodule

// File: rtl/nonrestoring_div16.sv
// Sequential unsigned non-restoring divider, serial operand load and result unload.
// Optional feature macro: DIV0_CHECK_EN (zero divisor skips iterations, returns all ones).
module nonrestoring_div16
    import nonrestoring_div16_pkg::*;
(
    input  logic          clk,
    input  logic          rst_b,
    input  logic [DW-1:0] inbus,
    output logic [DW-1:0] outbus
);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [DW-1:0]    a;
    logic [DW-1:0]    q;
    logic [DW-1:0]    m;
    logic             s;
    // Sign of the partial remainder before the shift; the shift pushes it out of S,
    // but it is what decides between add and subtract in the following step.
    logic             sgn;
    logic [DW:0]      sum;
    logic             sub;

    // Subtract only on an iteration step whose previous remainder was non-negative.
    always_comb begin
        sub = (state == ADDSUB) ? ~sgn : 1'b0;
    end

    div_addsub17 u_addsub (
        .sa  ({s, a}),
        .m   (m),
        .sub (sub),
        .sum (sum)
    );

    // Control FSM with the datapath registers and the registered output bus.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state   <= LD_A0;
            counter <= '0;
            a       <= '0;
            q       <= '0;
            m       <= '0;
            s       <= 1'b0;
            sgn     <= 1'b0;
            outbus  <= '0;
        end else begin
            unique case (state)
                LD_A0: state <= LD_A;
                LD_A: begin
                    a     <= inbus;
                    s     <= 1'b0;
                    state <= LD_Q0;
                end
                LD_Q0: state <= LD_Q;
                LD_Q: begin
                    q     <= inbus;
                    state <= LD_M0;
                end
                LD_M0: state <= LD_M;
                LD_M: begin
                    m       <= inbus;
                    counter <= '0;
`ifdef DIV0_CHECK_EN
                    if (inbus == '0) begin
                        a      <= '1;
                        q      <= '1;
                        outbus <= '1;
                        state  <= OUT_R;
                    end else begin
                        state <= SHIFT;
                    end
`else
                    state <= SHIFT;
`endif
                end
                SHIFT: begin
                    {s, a, q} <= {a, q, 1'b0};
                    sgn       <= s;
                    state     <= ADDSUB;
                end
                ADDSUB: begin
                    {s, a}  <= sum;
                    q[0]    <= ~sum[DW];
                    counter <= counter + 1'b1;
                    if (counter == CNT_W'(ITER_LAST)) begin
                        state <= CORRECT;
                    end else begin
                        state <= SHIFT;
                    end
                end
                CORRECT: begin
                    if (s) begin
                        {s, a} <= sum;
                        outbus <= sum[DW-1:0];
                    end else begin
                        outbus <= a;
                    end
                    state <= OUT_R;
                end
                OUT_R: begin
                    outbus <= q;
                    state  <= OUT_Q;
                end
                OUT_Q: begin
                    outbus <= '0;
                    state  <= DONE;
                end
                DONE: begin
                    outbus <= '0;
                end
                default: begin
                    outbus <= '0;
                    state  <= LD_A0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_div16.sv
// Bench for nonrestoring_div16: directed and random divisions against plain / and %.
// Every edge of each run is checked for the exact outbus word.
module tb_nonrestoring_div16;

    logic        clk;
    logic        rst_b;
    logic [15:0] inbus;
    logic [15:0] outbus;

    int checks = 0;
    int errors = 0;

`ifdef DIV0_CHECK_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    nonrestoring_div16 dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .inbus  (inbus),
        .outbus (outbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int e, input logic [15:0] exp);
        checks++;
        assert (outbus === exp) else begin
            errors++;
            $error("FAIL %s edge %0d: outbus=%h expected=%h", tag, e, outbus, exp);
        end
    endtask

    // Ends on a falling edge with reset released; next rising edge is edge 1.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_b = 1'b1;
        inbus = 16'($urandom);
        @(posedge clk);
        #1 check({tag, "_rst0"}, 0, 16'h0000);
        @(posedge clk);
        #1 check({tag, "_rst1"}, 0, 16'h0000);
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    // abort_at = 0 runs to completion; otherwise reset is asserted at that edge.
    task automatic run_div(input string tag, input logic [31:0] dvd,
                           input logic [15:0] dvs, input int abort_at);
        logic [15:0] r_exp;
        logic [15:0] q_exp;
        logic [15:0] exp;
        int          rpos;
        bit          skip;
        do_reset(tag);
        skip = 1'b0;
        rpos = 39;
        if (dvs == 16'h0) begin
            if (DZ) begin
                rpos  = 6;
                r_exp = 16'hFFFF;
                q_exp = 16'hFFFF;
            end else begin
                skip  = 1'b1;
                r_exp = 16'h0;
                q_exp = 16'h0;
            end
        end else begin
            r_exp = 16'(dvd % {16'h0, dvs});
            q_exp = 16'(dvd / {16'h0, dvs});
        end
        for (int e = 1; e <= 45; e++) begin
            if (e <= 2) inbus = dvd[31:16];
            else if (e <= 4) inbus = dvd[15:0];
            else if (e <= 6) inbus = dvs;
            else inbus = 16'($urandom);
            if (e == abort_at) begin
                rst_b = 1'b1;
                @(posedge clk);
                #1 check({tag, "_abort"}, e, 16'h0000);
                break;
            end
            @(posedge clk);
            if (e == rpos) exp = r_exp;
            else if (e == rpos + 1) exp = q_exp;
            else exp = 16'h0000;
            if (!(skip && (e == rpos || e == rpos + 1))) begin
                #1 check(tag, e, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] dvs;
        logic [31:0] dvd;
        rst_b = 1'b1;
        inbus = 16'h0;
        run_div("c1", 32'h0000_0010, 16'h0002, 0);
        run_div("c2", 32'h0001_0000, 16'h0003, 0);
        run_div("c3", 32'h1234_5678, 16'hFFFF, 0);
        run_div("c4", 32'h7FFF_FFFF, 16'h8000, 0);
        run_div("c5a", 32'h1234_5678, 16'hFFFF, 20);
        run_div("c5b", 32'h0000_0010, 16'h0002, 0);
        run_div("c6", 32'h0000_0005, 16'h0000, 0);
        run_div("maxq", 32'hFFFE_FFFF, 16'hFFFF, 0);
        run_div("one", 32'h0000_ABCD, 16'h0001, 0);
        for (int i = 0; i < 12; i++) begin
            dvs = 16'($urandom_range(1, 65535));
            dvd[31:16] = 16'($urandom % {16'h0, dvs});
            dvd[15:0]  = 16'($urandom);
            run_div("rnd", dvd, dvs, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
